// File: rtl/memory_controller.sv
// memory_controller: address/enable sequencer for an NxN by NxN matrix multiply; walks (i,j,k) with k innermost and writes C[i][j] after each inner product.
module memory_controller #(
  parameter int N      = 8,
  parameter int ADDR_W = 6,
  parameter int OUT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              we_A,
  output logic              we_B,
  output logic              we_out,
  output logic              en_A,
  output logic              en_B,
  output logic              en_out,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [OUT_W-1:0]  addr_out,
  output logic              done
);
  localparam int LW = $clog2(N);
  localparam int ZW = OUT_W - 2 * LW;

  typedef enum logic [1:0] {IDLE, READ, WB, FIN} state_t;

  state_t state, state_n;
  logic [LW-1:0] i, j, k, i_n, j_n, k_n;
  logic last_k, last_j, last_i;

  assign we_A   = 1'b0;
  assign we_B   = 1'b0;
  assign last_k = k == LW'(N - 1);
  assign last_j = j == LW'(N - 1);
  assign last_i = i == LW'(N - 1);

  always_comb begin
    state_n = state;
    i_n = i;
    j_n = j;
    k_n = k;
    unique case (state)
      IDLE: begin
        state_n = start ? READ : IDLE;
        i_n = '0;
        j_n = '0;
        k_n = '0;
      end
      READ: begin
        state_n = last_k ? WB : READ;
        k_n = last_k ? '0 : k + 1'b1;
      end
      WB: begin
        state_n = (last_j && last_i) ? FIN : READ;
        j_n = last_j ? '0 : j + 1'b1;
        i_n = last_j ? (last_i ? '0 : i + 1'b1) : i;
      end
      FIN: begin
        state_n = IDLE;
        i_n = '0;
        j_n = '0;
        k_n = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      en_A     <= 1'b0;
      en_B     <= 1'b0;
      en_out   <= 1'b0;
      we_out   <= 1'b0;
      addr_a   <= '0;
      addr_b   <= '0;
      addr_out <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      i        <= i_n;
      j        <= j_n;
      k        <= k_n;
      en_A     <= state_n == READ;
      en_B     <= state_n == READ;
      en_out   <= state_n == WB;
      we_out   <= state_n == WB;
      addr_a   <= state_n == READ ? {i_n, k_n} : '0;
      addr_b   <= state_n == READ ? {k_n, j_n} : '0;
      addr_out <= state_n == WB ? {{ZW{1'b0}}, i_n, j_n} : '0;
      done     <= state_n == FIN;
    end
  end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: directed cycle-by-cycle check of the full 8x8 multiply address sequence.
module tb_memory_controller;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic we_A, we_B, we_out, en_A, en_B, en_out, done;
  logic [5:0] addr_a, addr_b;
  logic [11:0] addr_out;
  logic [31:0] obs;
  int checks = 0;
  int errors = 0;

  memory_controller #(.N(8), .ADDR_W(6), .OUT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .we_A(we_A), .we_B(we_B), .we_out(we_out),
    .en_A(en_A), .en_B(en_B), .en_out(en_out),
    .addr_a(addr_a), .addr_b(addr_b), .addr_out(addr_out), .done(done)
  );

  always #5 clk = ~clk;

  assign obs = {1'b0, we_A, we_B, we_out, en_A, en_B, en_out, done, addr_a, addr_b, addr_out};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Expected packed outputs for cycle c after start was sampled (c=1 first READ, c=577 done).
  function automatic logic [31:0] expv(input int c);
    int e, r, ii, jj;
    logic [5:0] aa, ab;
    logic [11:0] ao;
    if (c == 577) return 32'h0100_0000;
    if (c < 1 || c > 577) return 32'h0;
    e = (c - 1) / 9;
    r = (c - 1) % 9;
    ii = e / 8;
    jj = e % 8;
    if (r < 8) begin
      aa = 6'(ii * 8 + r);
      ab = 6'(r * 8 + jj);
      return {1'b0, 6'b000110, 1'b0, aa, ab, 12'd0};
    end
    ao = 12'(e);
    return {1'b0, 6'b001001, 1'b0, 6'd0, 6'd0, ao};
  endfunction

  // mode 0: single start pulse; 1: start toggled while busy and during done; 2: start held high
  task automatic run(input int mode);
    int wes, dones;
    wes = 0;
    dones = 0;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 578; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("run%0d cyc%0d", mode, c), obs, expv(c));
      if (we_out) wes++;
      if (done) dones++;
      @(negedge clk) start = mode == 1 ? (c % 2 == 1 || c == 577) : mode == 2;
    end
    chk($sformatf("run%0d we_out count", mode), 32'(wes), 32'd64);
    chk($sformatf("run%0d done count", mode), 32'(dones), 32'd1);
  endtask

  initial begin
    #3;
    chk("reset outputs", obs, 32'h0);
    #20;
    @(negedge clk) rst_n = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("idle cyc%0d", c), obs, 32'h0);
    end
    run(0);
    run(1);
    run(2);
    // held start: a new run begins the cycle after the idle cycle; abort it inside element 20
    for (int c = 1; c <= 183; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rerun cyc%0d", c), obs, expv(c));
      @(negedge clk) start = 1'b0;
    end
    #1 rst_n = 1'b1;
    #1 chk("abort outputs", obs, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("in reset cyc%0d", c), obs, 32'h0);
    end
    @(negedge clk) rst_n = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post abort idle cyc%0d", c), obs, 32'h0);
    end
    run(0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Address/control sequencer for an 8x8 by 8x8 matrix-multiply engine.
- On a start pulse it drives read addresses into matrix memories A and B for every (i,j,k) inner-product term.
- After each inner product it issues one write strobe and address to the output memory, then pulses done.
- Pure control: no data ports. The datapath (MAC) sits beside it and follows its enables.

Parameters:
- N, 8, matrix dimension (power of two).
- ADDR_W, 6, A/B address width; must equal 2*log2(N).
- OUT_W, 12, output-memory address width; addr_out is zero-extended to this width.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-high (asserted = 1, despite the name).
- start  input  1  begin one full multiply; sampled only in IDLE.
- we_A  output  1  write enable for memory A; always 0 (A is read-only here).
- we_B  output  1  write enable for memory B; always 0.
- we_out  output  1  write enable for output memory.
- en_A  output  1  access enable for memory A.
- en_B  output  1  access enable for memory B.
- en_out  output  1  access enable for output memory.
- addr_a  output  ADDR_W  A read address = i*N+k.
- addr_b  output  ADDR_W  B read address = k*N+j.
- addr_out  output  OUT_W  output write address = i*N+j, zero-extended.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n=1, async): state=IDLE, counters i=j=k=0, all outputs 0. Reset mid-operation aborts immediately with no done pulse.
- Outputs are Moore: decoded from registered state and counters, with no combinational path from start.
- IDLE: all outputs 0. If start=1 at an edge, go to READ with i=j=k=0; otherwise stay.
- READ: en_A=en_B=1, we_A=we_B=0, addr_a=i*N+k, addr_b=k*N+j, en_out=we_out=0.
  - If k<N-1: k++ and stay in READ.
  - If k=N-1: k=0 and go to WB.
- WB: en_out=we_out=1, addr_out=i*N+j, en_A=en_B=0, addr_a=addr_b=0. Then advance:
  - If j<N-1: j++ and return to READ.
  - Else j=0. If i<N-1: i++ and return to READ.
  - Else (i=j=N-1): go to DONE.
- DONE: done=1 for exactly one cycle, all other outputs 0, counters cleared, go to IDLE unconditionally.
- start is ignored outside IDLE, including during the DONE cycle. If start is held high, a new run begins from IDLE one cycle after DONE.
- Addresses not listed as driven in a state are 0.
- Loop order: j inner over i; k innermost. Output addresses are written in order 0,1,...,N*N-1.
- Timing:
  - Each output element takes N READ cycles plus 1 WB cycle = 9 cycles.
  - A full run is 64*9 = 576 busy cycles.
  - With start sampled at edge E0, the first READ is the cycle after E0, and done is high in the 577th cycle after E0.
- The datapath captures memory data with 1-cycle read latency. The final product of an element is available during WB, so the MAC must accumulate it before or alongside the write; the controller adds no extra wait state.
- Width rules: i, j, k are each log2(N) bits. The address products are concatenations ({i,k}, {k,j}, {i,j}), not multipliers.

Test Plan:
- Reset: assert rst_n=1 mid-clock -> all outputs 0 immediately; deassert, hold start=0 for 10 cycles -> outputs stay 0, done=0.
- First element: pulse start for one cycle -> next 8 cycles have en_A=en_B=1, (addr_a,addr_b) = (0,0),(1,8),(2,16),...,(7,56); 9th cycle has we_out=en_out=1, addr_out=0.
- Second and last elements: second group gives addr_a=0..7, addr_b=1,9,...,57, then addr_out=1. Last group gives addr_a=56..63, addr_b=7,15,...,63, then addr_out=63.
- Completion: done=1 for exactly one cycle, 577 cycles after start was sampled; we_A=we_B=0 throughout; exactly 64 we_out pulses with addresses 0..63 in order.
- Start while busy: toggle start during READ/WB and during the DONE cycle -> sequence and timing unchanged, no restart.
- Abort and restart: assert rst_n=1 during element 20 -> outputs 0, no done. After release, a new start runs the full 576-cycle sequence from addr 0.
